// File: rtl/dct_mac_sequencer.sv
// Row buffer and MAC sequencer for the 1-D HEVC forward DCT (N = 4 or 8).
// Define DCT_SEQ_CLIP_FLAG_EN to add the out_clip saturation flag port.
module dct_mac_sequencer #(
   parameter int N = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [15:0] in_data,
   input  logic [4:0]         shift,
   output logic               mac_clear,
   output logic               mac_enable,
   output logic signed [15:0] mac_x,
   output logic signed [7:0]  mac_c,
   input  logic signed [31:0] mac_acc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [15:0] out_data,
   output logic [2:0]         out_idx,
   output logic               out_last
`ifdef DCT_SEQ_CLIP_FLAG_EN
   ,
   output logic               out_clip
`endif
);

   typedef enum logic [2:0] {S_LOAD, S_CLR, S_RUN, S_CAPT, S_OUT} state_t;

   localparam logic [2:0] LAST = 3'(N - 1);

   state_t             state_q, state_d;
   logic [2:0]         wptr_q, wptr_d;
   logic [3:0]         n_q, n_d, n_nxt;
   logic [2:0]         k_q, k_d;
   logic [4:0]         shift_q, shift_d;
   logic               in_ready_q, in_ready_d;
   logic               mac_clear_q, mac_clear_d;
   logic               mac_enable_q, mac_enable_d;
   logic signed [15:0] mac_x_q, mac_x_d;
   logic signed [7:0]  mac_c_q, mac_c_d;
   logic               out_valid_q, out_valid_d;
   logic signed [15:0] out_data_q, out_data_d;
   logic [2:0]         out_idx_q, out_idx_d;
   logic               out_last_q, out_last_d;
`ifdef DCT_SEQ_CLIP_FLAG_EN
   logic               clip_q, clip_d;
`endif

   logic               mem_we;
   logic signed [15:0] samp_mem [0:7];
   logic [2:0]         row;
   logic signed [32:0] acc_ext, rnd, rsum, r;
   logic               ovf_hi, ovf_lo;
   logic signed [15:0] sat;

   // 8-point HEVC matrix; row r holds c[r][0..7] with column 0 in the top byte.
   function automatic logic signed [7:0] coef(input logic [2:0] r_sel, input logic [2:0] col);
      logic [63:0] rb;
      case (r_sel)
         3'd0:    rb = {8{8'sd64}};
         3'd1:    rb = {8'sd89, 8'sd75, 8'sd50, 8'sd18, -8'sd18, -8'sd50, -8'sd75, -8'sd89};
         3'd2:    rb = {8'sd83, 8'sd36, -8'sd36, -8'sd83, -8'sd83, -8'sd36, 8'sd36, 8'sd83};
         3'd3:    rb = {8'sd75, -8'sd18, -8'sd89, -8'sd50, 8'sd50, 8'sd89, 8'sd18, -8'sd75};
         3'd4:    rb = {8'sd64, -8'sd64, -8'sd64, 8'sd64, 8'sd64, -8'sd64, -8'sd64, 8'sd64};
         3'd5:    rb = {8'sd50, -8'sd89, 8'sd18, 8'sd75, -8'sd75, -8'sd18, 8'sd89, -8'sd50};
         3'd6:    rb = {8'sd36, -8'sd83, 8'sd83, -8'sd36, -8'sd36, 8'sd83, -8'sd83, 8'sd36};
         default: rb = {8'sd18, -8'sd50, 8'sd75, -8'sd89, 8'sd89, -8'sd75, 8'sd50, -8'sd18};
      endcase
      return rb[63 - 8 * col -: 8];
   endfunction

   // The 4-point matrix is the even rows of the 8-point one.
   assign row = (N == 4) ? {k_q[1:0], 1'b0} : k_q;

   always_comb begin
      acc_ext = {mac_acc[31], mac_acc};
      rnd     = (shift_q == 5'd0) ? '0 : (33'sd1 <<< (shift_q - 5'd1));
      rsum    = acc_ext + rnd;
      r       = rsum >>> shift_q;
      ovf_hi  = (r > 33'sd32767);
      ovf_lo  = (r < -33'sd32768);
      sat     = ovf_hi ? 16'sh7FFF : (ovf_lo ? 16'sh8000 : r[15:0]);
   end

   always_comb begin
      state_d      = state_q;
      wptr_d       = wptr_q;
      n_d          = n_q;
      k_d          = k_q;
      shift_d      = shift_q;
      in_ready_d   = in_ready_q;
      mac_clear_d  = 1'b0;
      mac_enable_d = 1'b0;
      mac_x_d      = '0;
      mac_c_d      = '0;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_idx_d    = out_idx_q;
      out_last_d   = out_last_q;
`ifdef DCT_SEQ_CLIP_FLAG_EN
      clip_d       = clip_q;
`endif
      mem_we       = 1'b0;
      n_nxt        = n_q + 4'd1;

      case (state_q)
         S_LOAD: begin
            if (in_valid) begin
               mem_we = 1'b1;
               if (wptr_q == LAST) begin
                  shift_d     = shift;
                  k_d         = '0;
                  wptr_d      = '0;
                  in_ready_d  = 1'b0;
                  mac_clear_d = 1'b1;
                  state_d     = S_CLR;
               end else begin
                  wptr_d = wptr_q + 3'd1;
               end
            end
         end
         S_CLR: begin
            state_d      = S_RUN;
            n_d          = '0;
            mac_enable_d = 1'b1;
            mac_x_d      = samp_mem[0];
            mac_c_d      = coef(row, 3'd0);
         end
         S_RUN: begin
            // Outputs are registered, so each RUN cycle sets up the next term;
            // the n = N cycle drives zeros to flush the MAC's product register.
            if (n_q == 4'(N)) begin
               state_d = S_CAPT;
            end else begin
               n_d          = n_nxt;
               mac_enable_d = 1'b1;
               if (n_nxt != 4'(N)) begin
                  mac_x_d = samp_mem[n_nxt[2:0]];
                  mac_c_d = coef(row, n_nxt[2:0]);
               end
            end
         end
         S_CAPT: begin
            out_data_d  = sat;
            out_idx_d   = k_q;
            out_last_d  = (k_q == LAST);
            out_valid_d = 1'b1;
`ifdef DCT_SEQ_CLIP_FLAG_EN
            clip_d      = ovf_hi | ovf_lo;
`endif
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (k_q != LAST) begin
                  k_d         = k_q + 3'd1;
                  mac_clear_d = 1'b1;
                  state_d     = S_CLR;
               end else begin
                  wptr_d     = '0;
                  in_ready_d = 1'b1;
                  state_d    = S_LOAD;
               end
            end
         end
         default: begin
            in_ready_d = 1'b1;
            state_d    = S_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_LOAD;
         wptr_q       <= '0;
         n_q          <= '0;
         k_q          <= '0;
         shift_q      <= '0;
         in_ready_q   <= 1'b1;
         mac_clear_q  <= 1'b0;
         mac_enable_q <= 1'b0;
         mac_x_q      <= '0;
         mac_c_q      <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_idx_q    <= '0;
         out_last_q   <= 1'b0;
`ifdef DCT_SEQ_CLIP_FLAG_EN
         clip_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         wptr_q       <= wptr_d;
         n_q          <= n_d;
         k_q          <= k_d;
         shift_q      <= shift_d;
         in_ready_q   <= in_ready_d;
         mac_clear_q  <= mac_clear_d;
         mac_enable_q <= mac_enable_d;
         mac_x_q      <= mac_x_d;
         mac_c_q      <= mac_c_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_idx_q    <= out_idx_d;
         out_last_q   <= out_last_d;
`ifdef DCT_SEQ_CLIP_FLAG_EN
         clip_q       <= clip_d;
`endif
      end
   end

   // Sample buffer holds no control state, so it needs no reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         samp_mem[wptr_q] <= in_data;
      end
   end

   assign in_ready   = in_ready_q;
   assign mac_clear  = mac_clear_q;
   assign mac_enable = mac_enable_q;
   assign mac_x      = mac_x_q;
   assign mac_c      = mac_c_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_idx    = out_idx_q;
   assign out_last   = out_last_q;
`ifdef DCT_SEQ_CLIP_FLAG_EN
   assign out_clip   = clip_q;
`endif

endmodule

// File: tb/tb_dct_mac_sequencer.sv
// Directed bench: an N=8 and an N=4 sequencer, each driving a behavioural MAC model.
module tb_dct_mac_sequencer;

   logic               clk = 1'b0;
   logic               rst_n;
   int                 cyc = 0;
   int                 n_cmp = 0;
   int                 n_bad = 0;

   logic               in_valid   [2];
   logic               in_ready   [2];
   logic signed [15:0] in_data    [2];
   logic [4:0]         shift_in   [2];
   logic               mac_clear  [2];
   logic               mac_enable [2];
   logic signed [15:0] mac_x      [2];
   logic signed [7:0]  mac_c      [2];
   logic signed [31:0] mac_acc    [2];
   logic signed [23:0] mac_prod   [2];
   logic               out_valid  [2];
   logic               out_ready  [2];
   logic signed [15:0] out_data   [2];
   logic [2:0]         out_idx    [2];
   logic               out_last   [2];
`ifdef DCT_SEQ_CLIP_FLAG_EN
   logic               out_clip   [2];
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dct_mac_sequencer #(.N(8)) dut8 (
      .clk(clk), .reset_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .shift(shift_in[0]),
      .mac_clear(mac_clear[0]), .mac_enable(mac_enable[0]), .mac_x(mac_x[0]), .mac_c(mac_c[0]),
      .mac_acc(mac_acc[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_data(out_data[0]), .out_idx(out_idx[0]), .out_last(out_last[0])
`ifdef DCT_SEQ_CLIP_FLAG_EN
      , .out_clip(out_clip[0])
`endif
   );

   dct_mac_sequencer #(.N(4)) dut4 (
      .clk(clk), .reset_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .shift(shift_in[1]),
      .mac_clear(mac_clear[1]), .mac_enable(mac_enable[1]), .mac_x(mac_x[1]), .mac_c(mac_c[1]),
      .mac_acc(mac_acc[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_data(out_data[1]), .out_idx(out_idx[1]), .out_last(out_last[1])
`ifdef DCT_SEQ_CLIP_FLAG_EN
      , .out_clip(out_clip[1])
`endif
   );

   // MAC with a registered product: acc lags the product by one enabled cycle.
   always_ff @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (mac_clear[u]) begin
            mac_acc[u]  <= '0;
            mac_prod[u] <= '0;
         end else if (mac_enable[u]) begin
            mac_prod[u] <= mac_x[u] * mac_c[u];
            mac_acc[u]  <= mac_acc[u] + 32'(mac_prod[u]);
         end
      end
   end

   typedef struct packed {
      logic             unit;
      logic [4:0]       sh;
      logic             clip0;
      logic [0:7][15:0] samp;
      logic [0:7][15:0] expv;
   } vec_t;

   localparam int NV = 8;
   vec_t             vecs [NV];
   logic [0:7][15:0] ones;
   logic [0:7][15:0] ramp;

   function automatic int nu(input int u);
      return (u == 0) ? 8 : 4;
   endfunction

   task automatic chk(input string name, input bit ok, input int act, input int req);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   task automatic send_row(input int u, input logic [0:7][15:0] s, input logic [4:0] sh,
                           output int t_last);
      int g;
      t_last = 0;
      for (int i = 0; i < nu(u); i++) begin
         g = 0;
         @(negedge clk);
         while (!in_ready[u] && g < 100) begin
            @(negedge clk);
            g++;
         end
         if (g >= 100) chk("in_ready_timeout", 1'b0, 0, 1);
         in_valid[u] = 1'b1;
         in_data[u]  = s[i];
         shift_in[u] = sh;
         t_last      = cyc;
      end
      @(negedge clk);
      in_valid[u] = 1'b0;
      shift_in[u] = 5'd20;
   endtask

   task automatic wait_valid(input int u, output int t);
      int g;
      g = 0;
      while (!out_valid[u] && g < 60) begin
         @(negedge clk);
         g++;
      end
      if (g >= 60) chk("out_valid_timeout", 1'b0, 0, 1);
      t = cyc;
   endtask

   task automatic chk_out(input int u, input string tag, input int k, input logic [15:0] e,
                          input bit eclip);
      chk($sformatf("%s_data%0d", tag, k), out_data[u] == e, int'(out_data[u]), int'($signed(e)));
      chk($sformatf("%s_idx%0d", tag, k), out_idx[u] == 3'(k), int'(out_idx[u]), k);
      chk($sformatf("%s_last%0d", tag, k), out_last[u] == (k == nu(u) - 1),
          int'(out_last[u]), int'(k == nu(u) - 1));
`ifdef DCT_SEQ_CLIP_FLAG_EN
      chk($sformatf("%s_clip%0d", tag, k), out_clip[u] == eclip, int'(out_clip[u]), int'(eclip));
`else
      if (eclip) begin end
`endif
   endtask

   task automatic chk_reset(input int u, input string tag);
      chk($sformatf("%s_in_ready", tag), in_ready[u] == 1'b1, int'(in_ready[u]), 1);
      chk($sformatf("%s_out_ctl", tag), {out_valid[u], out_last[u], out_idx[u]} == 5'd0,
          int'({out_valid[u], out_last[u], out_idx[u]}), 0);
      chk($sformatf("%s_out_data", tag), out_data[u] == 16'sd0, int'(out_data[u]), 0);
      chk($sformatf("%s_mac_drive", tag),
          {mac_clear[u], mac_enable[u], mac_x[u], mac_c[u]} == 26'd0,
          int'({mac_clear[u], mac_enable[u], mac_x[u], mac_c[u]}), 0);
`ifdef DCT_SEQ_CLIP_FLAG_EN
      chk($sformatf("%s_clip", tag), out_clip[u] == 1'b0, int'(out_clip[u]), 0);
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, t0, t1, th, u;
      int exp_ctl, act_ctl, exp_x, exp_c;

      ones = {8{16'd1}};
      ramp = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
      vecs[0] = '{unit: 1'b0, sh: 5'd0, clip0: 1'b0, samp: ones, expv: {16'd512, {7{16'd0}}}};
      vecs[1] = '{unit: 1'b1, sh: 5'd7, clip0: 1'b0, samp: {16'd1, {7{16'd0}}},
                  expv: {16'd1, 16'd1, 16'd1, {5{16'd0}}}};
      vecs[2] = '{unit: 1'b1, sh: 5'd7, clip0: 1'b0, samp: {16'hFFFF, {7{16'd0}}},
                  expv: {16'd0, 16'hFFFF, {6{16'd0}}}};
      vecs[3] = '{unit: 1'b0, sh: 5'd0, clip0: 1'b1, samp: {8{16'd32767}},
                  expv: {16'd32767, {7{16'd0}}}};
      vecs[4] = '{unit: 1'b0, sh: 5'd0, clip0: 1'b1, samp: {8{16'h8000}},
                  expv: {16'h8000, {7{16'd0}}}};
      vecs[5] = '{unit: 1'b0, sh: 5'd2, clip0: 1'b0, samp: ramp,
                  expv: {16'd576, -16'sd291, 16'd0, -16'sd29, 16'd0, -16'sd8, 16'd0, -16'sd3}};
      vecs[6] = '{unit: 1'b1, sh: 5'd1, clip0: 1'b0,
                  samp: {16'd100, -16'sd200, 16'd300, -16'sd400, {4{16'd0}}},
                  expv: {-16'sd6400, 16'd11750, -16'sd12800, 16'd29750, {4{16'd0}}}};
      vecs[7] = '{unit: 1'b0, sh: 5'd20, clip0: 1'b0, samp: {8{16'd32767}},
                  expv: {16'd16, {7{16'd0}}}};

      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid[i]  = 1'b0;
         in_data[i]   = '0;
         shift_in[i]  = '0;
         out_ready[i] = 1'b1;
      end
      repeat (3) @(negedge clk);
      chk_reset(0, "rst8");
      chk_reset(1, "rst4");
      rst_n = 1'b1;

      // Table-driven rows.
      for (int v = 0; v < NV; v++) begin
         u = int'(vecs[v].unit);
         send_row(u, vecs[v].samp, vecs[v].sh, t);
         for (int k = 0; k < nu(u); k++) begin
            wait_valid(u, t);
            chk_out(u, $sformatf("v%0d", v), k, vecs[v].expv[k], (k == 0) && vecs[v].clip0);
            @(negedge clk);
         end
      end

      // Schedule and MAC drive for one output, then the inter-output period.
      send_row(0, ones, 5'd0, t0);
      for (int c = 1; c <= 12; c++) begin
         exp_ctl = int'({c == 1, c >= 2 && c <= 10, c == 12});
         act_ctl = int'({mac_clear[0], mac_enable[0], out_valid[0]});
         exp_x   = (c >= 2 && c <= 9) ? 1 : 0;
         exp_c   = (c >= 2 && c <= 9) ? 64 : 0;
         chk($sformatf("sched_ctl_T+%0d", cyc - t0), act_ctl == exp_ctl, act_ctl, exp_ctl);
         chk($sformatf("sched_x_T+%0d", cyc - t0), int'(mac_x[0]) == exp_x, int'(mac_x[0]), exp_x);
         chk($sformatf("sched_c_T+%0d", cyc - t0), int'(mac_c[0]) == exp_c, int'(mac_c[0]), exp_c);
         if (c < 12) @(negedge clk);
      end
      t1 = cyc;
      chk_out(0, "sched", 0, 16'd512, 1'b0);
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         wait_valid(0, t);
         chk($sformatf("period%0d", k), t - t1 == 12, t - t1, 12);
         chk_out(0, "sched", k, 16'd0, 1'b0);
         t1 = t;
      end
      @(negedge clk);

      // Backpressure at idx 3, with in_valid asserted while busy.
      send_row(0, ramp, 5'd2, t);
      for (int k = 0; k < 3; k++) begin
         wait_valid(0, t);
         chk_out(0, "bp", k, vecs[5].expv[k], 1'b0);
         @(negedge clk);
      end
      out_ready[0] = 1'b0;
      wait_valid(0, t);
      chk_out(0, "bp", 3, vecs[5].expv[3], 1'b0);
      for (int i = 0; i < 10; i++) begin
         in_valid[0] = 1'b1;
         in_data[0]  = 16'sd1000;
         @(negedge clk);
         chk($sformatf("bp_hold%0d", i),
             out_valid[0] && out_idx[0] == 3'd3 && out_data[0] == -16'sd29 &&
             !mac_enable[0] && !in_ready[0],
             int'({out_valid[0], out_idx[0], mac_enable[0], in_ready[0]}), 'b1_011_0_0);
      end
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      th = cyc;
      @(negedge clk);
      wait_valid(0, t);
      chk("bp_release_gap", t - th == 12, t - th, 12);
      for (int k = 4; k < 8; k++) begin
         if (k > 4) begin
            @(negedge clk);
            wait_valid(0, t);
         end
         chk_out(0, "bp", k, vecs[5].expv[k], 1'b0);
      end
      @(negedge clk);

      // Asynchronous reset in the middle of RUN.
      send_row(0, ones, 5'd0, t);
      repeat (2) @(negedge clk);
      chk("mr_in_run", mac_enable[0] == 1'b1, int'(mac_enable[0]), 1);
      rst_n = 1'b0;
      #1;
      chk_reset(0, "mr");
      @(negedge clk);
      rst_n = 1'b1;
      send_row(0, ones, 5'd0, t);
      for (int k = 0; k < 8; k++) begin
         wait_valid(0, t);
         chk_out(0, "mr", k, (k == 0) ? 16'd512 : 16'd0, 1'b0);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
